// File: rtl/pipeline_stall_sequencer_if.sv
// Pipeline hazard bus between the 5-stage datapath and the stall/flush sequencer.
// The master side is the datapath, which drives the hazard sources and consumes the controls.
// The slave side is the sequencer.
interface pipeline_stall_sequencer_if #(
    parameter int REG_W = 5
);
    // Hazard sources from the ID, EXE and MEM stages
    logic [REG_W-1:0] Source1_ID;
    logic [REG_W-1:0] Source2_ID;
    logic             UsesSource2_ID;
    logic             MulDivUse_ID;
    logic [REG_W-1:0] WriteRegister_IDEXE;
    logic             MemRead_IDEXE;
    logic             MulDivStart_IDEXE;
    logic             BranchTaken_EXE;
    logic             MemWait_MEM;

    // Pipeline register controls
    logic             STALL_IFID;
    logic             FLUSH_IFID;
    logic             STALL_IDEXE;
    logic             FLUSH_IDEXE;
    logic             STALL_EXEMEM;
    logic             FLUSH_EXEMEM;
    logic             STALL_MEMWB;
    logic             FLUSH_MEMWB;

    // Status and debug
    logic             MulDivBusy;
    logic [31:0]      StallCycles_DBG;
    logic [31:0]      FlushCount_DBG;

    modport master (
        output Source1_ID, Source2_ID, UsesSource2_ID, MulDivUse_ID,
        output WriteRegister_IDEXE, MemRead_IDEXE, MulDivStart_IDEXE,
        output BranchTaken_EXE, MemWait_MEM,
        input  STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE,
        input  STALL_EXEMEM, FLUSH_EXEMEM, STALL_MEMWB, FLUSH_MEMWB,
        input  MulDivBusy, StallCycles_DBG, FlushCount_DBG
    );

    modport slave (
        input  Source1_ID, Source2_ID, UsesSource2_ID, MulDivUse_ID,
        input  WriteRegister_IDEXE, MemRead_IDEXE, MulDivStart_IDEXE,
        input  BranchTaken_EXE, MemWait_MEM,
        output STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE,
        output STALL_EXEMEM, FLUSH_EXEMEM, STALL_MEMWB, FLUSH_MEMWB,
        output MulDivBusy, StallCycles_DBG, FlushCount_DBG
    );
endinterface

// File: rtl/pipeline_stall_sequencer.sv
// Central stall/flush scheduler for the 5-stage MIPS pipeline.
// It resolves four hazard sources in fixed priority:
//   1. data-memory wait freeze
//   2. taken-branch squash
//   3. MUL/DIV result wait
//   4. load-use bubble
// It also tracks the MUL/DIV busy window.
// The optional hazard statistics counters are built only when the macro
// HAZARD_STATS_EN is defined; otherwise both debug outputs are tied to zero.
// MULDIV_CYCLES must lie in 2..255 so that the 8-bit down-counter can hold it.
module pipeline_stall_sequencer #(
    parameter int MULDIV_CYCLES = 32,
    parameter int REG_W         = 5
) (
    input  logic                          CLOCK,
    input  logic                          RESET,
    pipeline_stall_sequencer_if.slave     bus
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        MDBUSY = 1'b1
    } state_t;

    // The counter is loaded with one less than the window length:
    // it runs N-1 .. 0, which gives exactly N busy cycles.
    localparam logic [7:0]       MD_LOAD  = 8'(MULDIV_CYCLES - 1);
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    state_t     state_q, state_d;
    logic [7:0] md_cnt_q, md_cnt_d;

    logic       md_busy;
    logic       freeze;
    logic       branch_flush;
    logic       md_wait;
    logic       load_use;

    logic       stall_ifid, flush_ifid;
    logic       stall_idexe, flush_idexe;
    logic       stall_exemem, flush_exemem;
    logic       stall_memwb, flush_memwb;

    assign md_busy = (state_q == MDBUSY);

    // MUL/DIV occupancy: state and down-counter registers
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= RUN;
            md_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // MUL/DIV next state.
    // A start is ignored while the unit is busy.
    // The count keeps running through memory freezes, because the unit is not
    // part of the frozen pipeline registers.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            RUN: begin
                if (bus.MulDivStart_IDEXE) begin
                    state_d  = MDBUSY;
                    md_cnt_d = MD_LOAD;
                end
            end
            MDBUSY: begin
                if (md_cnt_q == 8'd0) begin
                    state_d = RUN;
                end else begin
                    md_cnt_d = md_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d  = RUN;
                md_cnt_d = 8'd0;
            end
        endcase
    end

    // Hazard detection with priority folded in.
    // A freeze masks everything: the branch stays in EXE and is honoured later.
    // A taken branch squashes the wrong-path ID instruction, so any stall that
    // instruction would have caused is dropped.
    always_comb begin
        freeze       = bus.MemWait_MEM;
        branch_flush = bus.BranchTaken_EXE && !freeze;
        md_wait      = md_busy && bus.MulDivUse_ID && !freeze && !bus.BranchTaken_EXE;
        load_use     = bus.MemRead_IDEXE
                       && (bus.WriteRegister_IDEXE != REG_ZERO)
                       && ((bus.Source1_ID == bus.WriteRegister_IDEXE)
                           || (bus.UsesSource2_ID && (bus.Source2_ID == bus.WriteRegister_IDEXE)))
                       && !freeze && !bus.BranchTaken_EXE && !md_wait;
    end

    // Pipeline register controls.
    // While reset is held every register is flushed.
    // A stall/flush pair on the same register is never raised together.
    always_comb begin
        stall_ifid   = 1'b0;
        flush_ifid   = 1'b0;
        stall_idexe  = 1'b0;
        flush_idexe  = 1'b0;
        stall_exemem = 1'b0;
        flush_exemem = 1'b0;
        stall_memwb  = 1'b0;
        flush_memwb  = 1'b0;
        if (!RESET) begin
            flush_ifid   = 1'b1;
            flush_idexe  = 1'b1;
            flush_exemem = 1'b1;
            flush_memwb  = 1'b1;
        end else if (freeze) begin
            stall_ifid   = 1'b1;
            stall_idexe  = 1'b1;
            stall_exemem = 1'b1;
            flush_memwb  = 1'b1;
        end else if (branch_flush) begin
            flush_ifid   = 1'b1;
            flush_idexe  = 1'b1;
        end else if (md_wait || load_use) begin
            stall_ifid   = 1'b1;
            flush_idexe  = 1'b1;
        end
    end

    assign bus.STALL_IFID   = stall_ifid;
    assign bus.FLUSH_IFID   = flush_ifid;
    assign bus.STALL_IDEXE  = stall_idexe;
    assign bus.FLUSH_IDEXE  = flush_idexe;
    assign bus.STALL_EXEMEM = stall_exemem;
    assign bus.FLUSH_EXEMEM = flush_exemem;
    assign bus.STALL_MEMWB  = stall_memwb;
    assign bus.FLUSH_MEMWB  = flush_memwb;
    assign bus.MulDivBusy   = md_busy;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Statistics next-state.
    // Both counters wrap naturally at 2^32.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall_ifid) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (branch_flush) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    // Statistics registers, cleared by reset
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign bus.StallCycles_DBG = stall_cycles_q;
    assign bus.FlushCount_DBG  = flush_count_q;
`else
    assign bus.StallCycles_DBG = 32'd0;
    assign bus.FlushCount_DBG  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Scoreboard bench for pipeline_stall_sequencer (MULDIV_CYCLES=4).
// Each stimulus cycle pushes the expected control vector and the expected
// counter values; a negedge monitor pops them and compares.
// Build with HAZARD_STATS_EN defined to exercise the statistics counters.
module tb_pipeline_stall_sequencer;

    localparam int MDC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipeline_stall_sequencer_if #(.REG_W(5)) bus ();

    pipeline_stall_sequencer #(
        .MULDIV_CYCLES (MDC),
        .REG_W         (5)
    ) u_dut (
        .CLOCK (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    // Control vector order: {SI, FI, SD, FD, SE, FE, SM, FM, BUSY}
    typedef struct {
        string       tag;
        logic [8:0]  ctl;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests      = 0;
    int          n_fail       = 0;
    int          busy_left    = 0;
    logic        last_start   = 1'b0;
    logic        prev_stall   = 1'b0;
    logic        prev_brflush = 1'b0;
    logic [31:0] m_stall      = 32'd0;
    logic [31:0] m_flush      = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [8:0] sample_ctl();
        return {bus.STALL_IFID, bus.FLUSH_IFID, bus.STALL_IDEXE, bus.FLUSH_IDEXE,
                bus.STALL_EXEMEM, bus.FLUSH_EXEMEM, bus.STALL_MEMWB, bus.FLUSH_MEMWB,
                bus.MulDivBusy};
    endfunction

    // Expected controls from the stimulus currently applied plus the bench's busy model
    function automatic logic [8:0] model_ctl(input logic busy);
        logic [8:0] v;
        logic       lu;
        v  = 9'd0;
        lu = bus.MemRead_IDEXE && (bus.WriteRegister_IDEXE != 5'd0) &&
             ((bus.Source1_ID == bus.WriteRegister_IDEXE) ||
              (bus.UsesSource2_ID && (bus.Source2_ID == bus.WriteRegister_IDEXE)));
        if (bus.MemWait_MEM) begin
            v[8] = 1'b1;
            v[6] = 1'b1;
            v[4] = 1'b1;
            v[1] = 1'b1;
        end else if (bus.BranchTaken_EXE) begin
            v[7] = 1'b1;
            v[5] = 1'b1;
        end else if ((busy && bus.MulDivUse_ID) || lu) begin
            v[8] = 1'b1;
            v[5] = 1'b1;
        end
        v[0] = busy;
        return v;
    endfunction

    task automatic drive(input string tag, input logic [4:0] s1, input logic [4:0] s2,
                         input logic us2, input logic mdu, input logic [4:0] wr,
                         input logic mr, input logic st, input logic br, input logic mw);
        exp_t       e;
        logic [8:0] c;
        @(posedge clk);
        #1;
        // Advance the models by the edge just taken
        if (busy_left > 0) begin
            busy_left--;
        end else if (last_start) begin
            busy_left = MDC;
        end
        if (prev_stall) m_stall++;
        if (prev_brflush) m_flush++;
        bus.Source1_ID          = s1;
        bus.Source2_ID          = s2;
        bus.UsesSource2_ID      = us2;
        bus.MulDivUse_ID        = mdu;
        bus.WriteRegister_IDEXE = wr;
        bus.MemRead_IDEXE       = mr;
        bus.MulDivStart_IDEXE   = st;
        bus.BranchTaken_EXE     = br;
        bus.MemWait_MEM         = mw;
        c            = model_ctl(busy_left > 0);
        last_start   = st;
        prev_stall   = c[8];
        prev_brflush = br && !mw;
        e.tag = tag;
        e.ctl = c;
`ifdef HAZARD_STATS_EN
        e.stall_cnt = m_stall;
        e.flush_cnt = m_flush;
`else
        e.stall_cnt = 32'd0;
        e.flush_cnt = 32'd0;
`endif
        sb_q.push_back(e);
    endtask

    task automatic idle(input string tag);
        drive(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset assertion mid-cycle, checked before any clock edge
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n                   = 1'b0;
        bus.Source1_ID          = 5'd0;
        bus.Source2_ID          = 5'd0;
        bus.UsesSource2_ID      = 1'b0;
        bus.MulDivUse_ID        = 1'b0;
        bus.WriteRegister_IDEXE = 5'd0;
        bus.MemRead_IDEXE       = 1'b0;
        bus.MulDivStart_IDEXE   = 1'b0;
        bus.BranchTaken_EXE     = 1'b0;
        bus.MemWait_MEM         = 1'b0;
        #1;
        check({tag, "_ctl"}, 32'(sample_ctl()), 32'(9'b010101010));
        check({tag, "_stallcnt"}, bus.StallCycles_DBG, 32'd0);
        check({tag, "_flushcnt"}, bus.FlushCount_DBG, 32'd0);
        busy_left    = 0;
        last_start   = 1'b0;
        prev_stall   = 1'b0;
        prev_brflush = 1'b0;
        m_stall      = 32'd0;
        m_flush      = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare every pushed expectation against the DUT in the same cycle
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, "_ctl"}, 32'(sample_ctl()), 32'(e.ctl));
            check({e.tag, "_stallcnt"}, bus.StallCycles_DBG, e.stall_cnt);
            check({e.tag, "_flushcnt"}, bus.FlushCount_DBG, e.flush_cnt);
        end
    end

    initial begin
        do_reset("reset0");

        // Load-use on rs, then a clean cycle
        drive("lw5_rs", 5'd5, 5'd1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("after_lu");
        // $0 never stalls; rt match without rt use does not stall, with use does
        drive("lw0", 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("rt_unused", 5'd3, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("rt_used", 5'd3, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("no_load", 5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);

        // MUL/DIV window with mfhi waiting; a second start while busy is ignored
        drive("md_start", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive("mfhi_w1", 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("mfhi_w2", 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive("mfhi_w3", 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("mfhi_w4", 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive("mfhi_go", 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle("md_done");

        // Independent add flows while busy
        drive("md_start2", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < MDC + 1; i++) begin
            drive("add_flow", 5'd3, 5'd4, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Branch overrides load-use; start together with a taken branch
        drive("br_lu", 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        drive("br_start", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive("br_mdwait", 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < MDC; i++) idle("br_md_drain");

        // Freeze with a branch held, then the branch is honoured
        do_reset("reset1");
        for (int i = 0; i < 3; i++) begin
            drive("freeze", 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        drive("br_after_frz", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle("stats_after");

        // Reset in the middle of a busy window
        drive("md_start3", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle("md_mid1");
        idle("md_mid2");
        do_reset("reset_mid_md");
        idle("post_rst1");
        idle("post_rst2");

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
